saed32_128x8_port_arbiter: RTL and testbench
============================================

// Module: saed32_128x8_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing one wrap_saed32_128x8 dual-port SRAM (ports 0/1) among N_REQ requesters.
//  - Grants up to two requests per cycle, one per SRAM port.
//  - Registers the SRAM drive signals.
//  - Returns read data to the owning requester with fixed latency.
//  Sits between local memory clients and the SRAM wrapper instance.
// PARAMETERS
//  N_REQ   4  number of requesters, 2..8
//  ADDR_W  7  address width; must match the macro (128 words)
//  DATA_W  8  data and write-mask width
// PORTS
//  CLK     in   1               clock; SRAM and all state are rising-edge
//  RSTN    in   1               asynchronous active-low reset
//  REQ     in   N_REQ           per-requester request
//  WE      in   N_REQ           1=write, 0=read; qualified by REQ
//  ADDR    in   N_REQ*ADDR_W    flattened addresses; slice i = requester i
//  WDATA   in   N_REQ*DATA_W    flattened write data
//  WMASK   in   N_REQ*DATA_W    flattened bit write mask; passed to WEMx
//  GNT     out  N_REQ           combinational grant; REQ&GNT = accepted
//  RVALID  out  N_REQ           read data valid for requester i
//  RDATA   out  N_REQ*DATA_W    flattened read data; valid only with RVALID[i]
//  A0/A1   out  ADDR_W          SRAM port addresses (registered)
//  D0/D1   out  DATA_W          SRAM write data (registered)
//  WEM0/1  out  DATA_W          SRAM write masks (registered)
//  WE0/1   out  1               SRAM write enables (registered)
//  CE0/1   out  1               SRAM port enables (registered)
//  Q0/Q1   in   DATA_W          SRAM read data, valid the cycle after CEx sampled
// BEHAVIOUR
//  Reset (RSTN=0, asynchronous):
//  - CE0/1, WE0/1, RVALID, all tag valids = 0.
//  - A/D/WEM = 0. PTR = 0.
//  - GNT = 0 while RSTN=0.
//  Arbitration (combinational, cycle t):
//  - Scan requesters PTR, PTR+1, ... mod N_REQ.
//  - First REQ found -> port 0. Second REQ found -> port 1.
//  - Others get GNT=0 and must hold REQ and all fields stable until granted.
//  Conflict rule:
//  - The second candidate is skipped if its ADDR equals the port-0 winner's ADDR and either is a write.
//  - The scan then continues to the next REQ. Read/read to the same address is allowed.
//  PTR update:
//  - If any grant at t, PTR <= (index of the last granted requester + 1) mod N_REQ.
//  - Otherwise PTR holds.
//  Issue (t+1):
//  - The CEx/WEx/Ax/Dx/WEMx registers load the winner's fields; CEx=0 if the port is unused.
//  - A 3-bit owner tag per port is registered with rvld = CE & ~WE.
//  Return (t+2):
//  - The tag advances one more stage.
//  - RVALID[tag] = 1 and RDATA[tag] = Qx, combinational from the macro output.
//  - Read latency is exactly 2 cycles from the handshake.
//  - Writes produce no response.
//  - Full throughput: 2 accesses/cycle, no bubbles.
//  Ordering and hazards:
//  - Two grants to the same requester in one cycle are impossible: one slot per requester per cycle.
//  - A read granted the cycle after a write to the same address returns the new data. The macro is synchronous, so no bypass is needed.
//  Mid-operation reset:
//  - In-flight reads are dropped; no RVALID is generated after RSTN deasserts.
//  - PTR restarts at 0.
//  - N_REQ not a power of 2: PTR wraps from N_REQ-1 to 0.
// TESTING
//  T1 reset: RSTN=0 mid-read -> RVALID=0, CE0=CE1=0, GNT=0; after release, first grant goes to req0.
//  T2 single: req2 writes A=0x05, D=0xA5. Next req2 reads A=0x05 -> GNT[2] each cycle; RVALID[2] 2 cycles after the read, RDATA=0xA5.
//  T3 round-robin: all 4 REQ held reads at PTR=0 -> grants {0,1}, {2,3}, {0,1}. Each RVALID arrives 2 cycles later with the correct RDATA slice.
//  T4 conflict: req0 writes 0x10 and req1 reads 0x10 at PTR=0, req3 reads 0x20 -> grants 0 and 3; req1 is granted next cycle and reads the new data.
//  T5 read/read same address: req1 and req2 read 0x7F -> both granted, both RVALID with identical RDATA.
//  T6 wrap: N_REQ=3; req2 only, then req0+req2 -> grant 2, then grant 0 (port 0) and 2 (port 1); PTR wraps 2->0->0.

Source files
------------

// File: rtl/saed32_128x8_port_arbiter.sv
// -----------------------------------------------------------------------------
// saed32_128x8_port_arbiter
//
// Round-robin arbiter that shares one dual-port 128x8 SRAM wrapper
// (wrap_saed32_128x8, ports 0 and 1) among N_REQ local requesters.
//
// Each cycle the arbiter can grant up to two requests, one on each SRAM port.
// The SRAM drive signals are registered. Read data goes back to the requester
// that owns it exactly two cycles after the request/grant handshake.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   req[N_REQ]          per-requester request
//   we[N_REQ]           1 = write, 0 = read (qualified by req)
//   addr, wdata, wmask  flattened per-requester fields (slice i = requester i)
//   gnt[N_REQ]          combinational grant; req & gnt = accepted this cycle
//   rvalid, rdata       read return, rdata slice i valid only with rvalid[i]
//   a0/a1 d0/d1 wem0/wem1 we0/we1 ce0/ce1
//                       registered SRAM port drive
//   q0/q1               SRAM read data, valid the cycle after ce was sampled
// -----------------------------------------------------------------------------
module saed32_128x8_port_arbiter #(
  parameter int N_REQ  = 4,   // 2..8 (owner tags are 3 bits)
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         we,
  input  logic [N_REQ*ADDR_W-1:0]  addr,
  input  logic [N_REQ*DATA_W-1:0]  wdata,
  input  logic [N_REQ*DATA_W-1:0]  wmask,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rvalid,
  output logic [N_REQ*DATA_W-1:0]  rdata,
  output logic [ADDR_W-1:0]        a0,
  output logic [ADDR_W-1:0]        a1,
  output logic [DATA_W-1:0]        d0,
  output logic [DATA_W-1:0]        d1,
  output logic [DATA_W-1:0]        wem0,
  output logic [DATA_W-1:0]        wem1,
  output logic                     we0,
  output logic                     we1,
  output logic                     ce0,
  output logic                     ce1,
  input  logic [DATA_W-1:0]        q0,
  input  logic [DATA_W-1:0]        q1
);

  // One registered SRAM port drive.
  typedef struct packed {
    logic              ce;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] wem;
  } port_t;

  // Owner tag that follows a read down the two-cycle return pipeline.
  typedef struct packed {
    logic       vld;
    logic [2:0] owner;
  } tag_t;

  logic [2:0] ptr, ptr_nxt;
  logic [2:0] idx, win0, win1;
  logic       hit0, hit1;
  port_t      p0_nxt, p1_nxt, p0_q, p1_q;
  tag_t       tag1 [2];
  tag_t       tag2 [2];

  // (base + off) mod N_REQ, for off in 0..N_REQ. This also handles N_REQ that
  // is not a power of two.
  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[2:0];
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [2:0] i);
    return addr[int'(i)*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] wdata_of(input logic [2:0] i);
    return wdata[int'(i)*DATA_W +: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] wmask_of(input logic [2:0] i);
    return wmask[int'(i)*DATA_W +: DATA_W];
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration: scan from ptr. The first requester found takes port 0. The
  // next requester found takes port 1 unless it would touch port 0's address
  // with a write on either side; in that case it is skipped and the scan goes on.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no
    // path through the block leaves it unassigned and a latch cannot be inferred.
    hit0 = 1'b0;
    hit1 = 1'b0;
    win0 = '0;
    win1 = '0;
    idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = wrap_idx(ptr, k);
      if (req[idx]) begin
        if (!hit0) begin
          hit0 = 1'b1;
          win0 = idx;
        end else if (!hit1 &&
                     !((addr_of(idx) == addr_of(win0)) && (we[idx] || we[win0]))) begin
          hit1 = 1'b1;
          win1 = idx;
        end
      end
    end
  end

  // The port-1 winner is always later in scan order than the port-0 winner,
  // so it is the last requester granted whenever it exists.
  always_comb begin
    ptr_nxt = ptr;
    if (hit1)      ptr_nxt = wrap_idx(win1, 1);
    else if (hit0) ptr_nxt = wrap_idx(win0, 1);
  end

  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (hit0) gnt[win0] = 1'b1;
      if (hit1) gnt[win1] = 1'b1;
    end
  end

  // Next SRAM drive for each port. An unused port issues ce = 0 and zero fields.
  always_comb begin
    p0_nxt = '0;
    p1_nxt = '0;
    if (hit0) begin
      p0_nxt.ce  = 1'b1;
      p0_nxt.we  = we[win0];
      p0_nxt.a   = addr_of(win0);
      p0_nxt.d   = wdata_of(win0);
      p0_nxt.wem = wmask_of(win0);
    end
    if (hit1) begin
      p1_nxt.ce  = 1'b1;
      p1_nxt.we  = we[win1];
      p1_nxt.a   = addr_of(win1);
      p1_nxt.d   = wdata_of(win1);
      p1_nxt.wem = wmask_of(win1);
    end
  end

  // ---------------------------------------------------------------------------
  // State: round-robin pointer, SRAM drive registers, and return tag pipeline.
  // Reset discards in-flight reads because it clears both tag stages.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      // NOTE: the address, data and mask registers are reset as well as the
      // enables, so the SRAM pins carry a known value straight out of reset.
      p0_q    <= '0;
      p1_q    <= '0;
      tag1[0] <= '0;
      tag1[1] <= '0;
      tag2[0] <= '0;
      tag2[1] <= '0;
    end else begin
      // NOTE: non-blocking assignments, so each stage samples the previous
      // stage's old value and the pipeline moves exactly one step per edge.
      ptr           <= ptr_nxt;
      p0_q          <= p0_nxt;
      p1_q          <= p1_nxt;
      tag1[0].vld   <= p0_nxt.ce & ~p0_nxt.we;
      tag1[0].owner <= win0;
      tag1[1].vld   <= p1_nxt.ce & ~p1_nxt.we;
      tag1[1].owner <= win1;
      tag2[0]       <= tag1[0];
      tag2[1]       <= tag1[1];
    end
  end

  assign ce0  = p0_q.ce;
  assign we0  = p0_q.we;
  assign a0   = p0_q.a;
  assign d0   = p0_q.d;
  assign wem0 = p0_q.wem;
  assign ce1  = p1_q.ce;
  assign we1  = p1_q.we;
  assign a1   = p1_q.a;
  assign d1   = p1_q.d;
  assign wem1 = p1_q.wem;

  // Return: the macro output is steered to the tag's owner. Both ports can
  // never point at the same owner, because a requester holds only one slot
  // per cycle.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (tag2[0].vld) begin
      rvalid[tag2[0].owner]                           = 1'b1;
      rdata[int'(tag2[0].owner)*DATA_W +: DATA_W]     = q0;
    end
    if (tag2[1].vld) begin
      rvalid[tag2[1].owner]                           = 1'b1;
      rdata[int'(tag2[1].owner)*DATA_W +: DATA_W]     = q1;
    end
  end

endmodule

// File: tb/tb_saed32_128x8_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_saed32_128x8_port_arbiter
//
// Bench for the 4-requester arbiter, using a behavioural dual-port SRAM model.
// The reference model works from the arbitration rules: an ordered candidate
// list, a word-level memory image, and a queue of pending read responses.
// Directed sequences pin the model with literal values. A random phase then
// compares every cycle. A second instance with 3 requesters exercises
// non-power-of-two pointer wrap.
// -----------------------------------------------------------------------------
module tb_saed32_128x8_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 7;
  localparam int DW = 8;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req, we, gnt, rvalid;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata, wmask, rdata;
  logic [AW-1:0]     a0, a1;
  logic [DW-1:0]     d0, d1, wem0, wem1, q0, q1;
  logic              we0, we1, ce0, ce1;

  // 3-requester instance (pointer wrap); its SRAM side is left idle.
  logic [2:0]        req3n, gnt3n, rvalid3n;
  logic [3*AW-1:0]   addr3n;
  logic [3*DW-1:0]   wdata3n, wmask3n, rdata3n;
  logic [AW-1:0]     a0_3n, a1_3n;
  logic [DW-1:0]     d0_3n, d1_3n, wem0_3n, wem1_3n;
  logic              we0_3n, we1_3n, ce0_3n, ce1_3n;

  // Stimulus for the main instance, one entry per requester.
  logic              s_req   [N];
  logic              s_we    [N];
  logic [AW-1:0]     s_addr  [N];
  logic [DW-1:0]     s_wdata [N];
  logic [DW-1:0]     s_wmask [N];

  // Outputs sampled on the falling edge.
  logic [N-1:0]      s_gnt, s_rvalid;
  logic [N*DW-1:0]   s_rdata;
  logic              s_ce0, s_ce1, s_we0;
  logic [AW-1:0]     s_a0;
  logic [DW-1:0]     s_d0;
  logic [2:0]        s_gnt3;

  // Reference model state.
  typedef struct {
    int          due;
    int          who;
    logic [7:0]  data;
  } resp_t;
  int          m_ptr;
  logic [7:0]  m_mem [128];
  resp_t       m_q [$];

  int checks;
  int errors;
  int cyc;

  // Behavioural SRAM: one-cycle synchronous read, bit-masked write.
  logic [7:0]  sram [128];
  logic        sram_load;

  saed32_128x8_port_arbiter #(.N_REQ(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .wmask(wmask), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .a0(a0), .a1(a1), .d0(d0), .d1(d1), .wem0(wem0), .wem1(wem1),
    .we0(we0), .we1(we1), .ce0(ce0), .ce1(ce1), .q0(q0), .q1(q1)
  );

  saed32_128x8_port_arbiter #(.N_REQ(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3n), .we(3'b000), .addr(addr3n),
    .wdata(wdata3n), .wmask(wmask3n), .gnt(gnt3n), .rvalid(rvalid3n),
    .rdata(rdata3n), .a0(a0_3n), .a1(a1_3n), .d0(d0_3n), .d1(d1_3n),
    .wem0(wem0_3n), .wem1(wem1_3n), .we0(we0_3n), .we1(we1_3n),
    .ce0(ce0_3n), .ce1(ce1_3n), .q0(8'h00), .q1(8'h00)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign addr3n  = {7'd3, 7'd2, 7'd1};
  assign wdata3n = '0;
  assign wmask3n = '0;

  always_comb begin
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    wmask = '0;
    for (int i = 0; i < N; i++) begin
      req[i]              = s_req[i];
      we[i]               = s_we[i];
      addr[i*AW +: AW]    = s_addr[i];
      wdata[i*DW +: DW]   = s_wdata[i];
      wmask[i*DW +: DW]   = s_wmask[i];
    end
  end

  always @(posedge clk) begin
    if (sram_load) begin
      for (int i = 0; i < 128; i++) sram[i] <= 8'(i) ^ 8'h5A;
    end else begin
      if (ce0 && we0)  sram[a0] <= (sram[a0] & ~wem0) | (d0 & wem0);
      if (ce0 && !we0) q0 <= sram[a0];
      if (ce1 && we1)  sram[a1] <= (sram[a1] & ~wem1) | (d1 & wem1);
      if (ce1 && !we1) q1 <= sram[a1];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Candidates in rotation order from the model pointer. The first one wins
  // port 0. The first later one that does not clash with it wins port 1.
  function automatic void model_arb(output int p0, output int p1);
    int cand[$];
    p0 = -1;
    p1 = -1;
    for (int k = 0; k < N; k++)
      if (s_req[(m_ptr + k) % N]) cand.push_back((m_ptr + k) % N);
    if (cand.size() > 0) p0 = cand[0];
    for (int j = 1; j < cand.size(); j++) begin
      if (s_addr[cand[j]] != s_addr[p0] || (!s_we[cand[j]] && !s_we[p0])) begin
        p1 = cand[j];
        break;
      end
    end
  endfunction

  // One clock cycle: sample on the falling edge, compare, advance the model,
  // and return just after the next rising edge so the caller can drive.
  task automatic step();
    int         p0, p1;
    int         w[2];
    logic [N-1:0] eg, ev;
    @(negedge clk);
    cyc++;
    s_gnt    = gnt;
    s_rvalid = rvalid;
    s_rdata  = rdata;
    s_ce0    = ce0;
    s_ce1    = ce1;
    s_we0    = we0;
    s_a0     = a0;
    s_d0     = d0;
    s_gnt3   = gnt3n;
    if (!rst_n) begin
      check("rst_gnt",    32'(gnt),    32'h0);
      check("rst_rvalid", 32'(rvalid), 32'h0);
      check("rst_ce",     {30'b0, ce1, ce0}, 32'h0);
      m_ptr = 0;
      m_q.delete();
    end else begin
      model_arb(p0, p1);
      eg = '0;
      if (p0 >= 0) eg[p0] = 1'b1;
      if (p1 >= 0) eg[p1] = 1'b1;
      check("gnt", 32'(gnt), 32'(eg));
      ev = '0;
      while (m_q.size() > 0 && m_q[0].due <= cyc) begin
        ev[m_q[0].who] = 1'b1;
        if (rvalid[m_q[0].who])
          check("rdata", 32'(rdata[m_q[0].who*DW +: DW]), 32'(m_q[0].data));
        void'(m_q.pop_front());
      end
      check("rvalid", 32'(rvalid), 32'(ev));
      w[0] = p0;
      w[1] = p1;
      // Reads see the memory as it was before this cycle's writes. Same-cycle
      // write/read to one address cannot both be granted.
      for (int j = 0; j < 2; j++)
        if (w[j] >= 0 && !s_we[w[j]])
          m_q.push_back('{due: cyc + 2, who: w[j], data: m_mem[s_addr[w[j]]]});
      for (int j = 0; j < 2; j++)
        if (w[j] >= 0 && s_we[w[j]])
          m_mem[s_addr[w[j]]] = (m_mem[s_addr[w[j]]] & ~s_wmask[w[j]]) |
                                (s_wdata[w[j]] & s_wmask[w[j]]);
      if (p1 >= 0)      m_ptr = (p1 + 1) % N;
      else if (p0 >= 0) m_ptr = (p0 + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) s_req[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic w, input logic [6:0] a,
                         input logic [7:0] d, input logic [7:0] m);
    s_req[i]   = 1'b1;
    s_we[i]    = w;
    s_addr[i]  = a;
    s_wdata[i] = d;
    s_wmask[i] = m;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    m_ptr  = 0;
    req3n  = '0;
    for (int i = 0; i < N; i++) begin
      s_req[i] = 1'b0; s_we[i] = 1'b0; s_addr[i] = '0; s_wdata[i] = '0; s_wmask[i] = '0;
    end
    for (int i = 0; i < 128; i++) m_mem[i] = 8'(i) ^ 8'h5A;
    rst_n     = 1'b0;
    sram_load = 1'b1;
    step();
    sram_load = 1'b0;
    step();
    check("rst_a0",  32'(s_a0),  32'h0);
    check("rst_d0",  32'(s_d0),  32'h0);
    rst_n = 1'b1;

    // Round robin: all four hold reads, starting from ptr 0.
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 7'(8'h40 + i), 8'h00, 8'h00);
    step();
    check("rr_gnt_c1", 32'(s_gnt), 32'h3);
    step();
    check("rr_gnt_c2", 32'(s_gnt), 32'hC);
    step();
    check("rr_gnt_c3",  32'(s_gnt),    32'h3);
    check("rr_rv_c3",   32'(s_rvalid), 32'h3);
    check("rr_rd0_c3",  32'(s_rdata[7:0]), 32'h1A);
    idle_all();
    set_req(3, 1'b0, 7'h43, 8'h00, 8'h00);
    step();
    check("rr_gnt_c4",  32'(s_gnt),    32'h8);
    check("rr_rv_c4",   32'(s_rvalid), 32'hC);
    check("rr_rd3_c4",  32'(s_rdata[31:24]), 32'h19);

    // Single requester: write, then read back.
    idle_all();
    set_req(2, 1'b1, 7'h05, 8'hA5, 8'hFF);
    step();
    check("single_gnt_w", 32'(s_gnt), 32'h4);
    set_req(2, 1'b0, 7'h05, 8'h00, 8'h00);
    step();
    check("single_gnt_r", 32'(s_gnt), 32'h4);
    check("issue_port0",  {14'b0, s_ce0, s_we0, s_a0, s_d0}, {14'b0, 1'b1, 1'b1, 7'h05, 8'hA5});
    idle_all();
    set_req(3, 1'b0, 7'h00, 8'h00, 8'h00);
    step();

    // Conflict: req0 writes 0x10, req1 reads 0x10, req3 reads 0x20.
    idle_all();
    set_req(0, 1'b1, 7'h10, 8'h3C, 8'hFF);
    set_req(1, 1'b0, 7'h10, 8'h00, 8'h00);
    set_req(3, 1'b0, 7'h20, 8'h00, 8'h00);
    step();
    check("cf_gnt_a",   32'(s_gnt),    32'h9);
    check("single_rv",  32'(s_rvalid), 32'h4);
    check("single_rd",  32'(s_rdata[23:16]), 32'hA5);
    s_req[0] = 1'b0;
    s_req[3] = 1'b0;
    step();
    check("cf_gnt_b", 32'(s_gnt), 32'h2);
    idle_all();
    step();
    check("cf_rd3", 32'(s_rdata[31:24]), 32'h7A);
    step();
    check("cf_rv1", 32'(s_rvalid), 32'h2);
    check("cf_rd1", 32'(s_rdata[15:8]), 32'h3C);

    // Read/read to one address, with ptr at 2.
    set_req(1, 1'b0, 7'h7F, 8'h00, 8'h00);
    set_req(2, 1'b0, 7'h7F, 8'h00, 8'h00);
    step();
    check("rr_same_gnt", 32'(s_gnt), 32'h6);
    idle_all();
    step();
    step();
    check("rr_same_rv",  32'(s_rvalid), 32'h6);
    check("rr_same_rd",  {16'b0, s_rdata[23:16], s_rdata[15:8]}, 32'h2525);

    // Reset with a read in flight; the read must never come back.
    set_req(0, 1'b0, 7'h01, 8'h00, 8'h00);
    step();
    idle_all();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("mid_rst_rv_a", 32'(s_rvalid), 32'h0);
    step();
    check("mid_rst_rv_b", 32'(s_rvalid), 32'h0);
    set_req(0, 1'b0, 7'h02, 8'h00, 8'h00);
    set_req(3, 1'b0, 7'h03, 8'h00, 8'h00);
    step();
    check("post_rst_gnt", 32'(s_gnt), 32'h9);
    idle_all();

    // Three requesters: the pointer wraps 2 -> 0.
    req3n = 3'b010;
    step();
    check("wrap_gnt_a", 32'(s_gnt3), 32'h2);
    req3n = 3'b100;
    step();
    check("wrap_gnt_b", 32'(s_gnt3), 32'h4);
    req3n = 3'b101;
    step();
    check("wrap_gnt_c", 32'(s_gnt3), 32'h5);
    req3n = 3'b110;
    step();
    check("wrap_gnt_d", 32'(s_gnt3), 32'h6);
    req3n = 3'b000;

    // Random traffic. A request is held until it is granted. A small address
    // pool keeps conflicts and read-after-write frequent.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!s_req[i] || s_gnt[i]) begin
          s_req[i]   = ($urandom_range(0, 9) < 7);
          s_we[i]    = $urandom_range(0, 2) == 0;
          s_addr[i]  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                   : 7'($urandom_range(0, 7));
          s_wdata[i] = 8'($urandom);
          s_wmask[i] = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
        end
      end
      step();
    end
    idle_all();
    step();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
